// File: rtl/gsim_rhs_gen.sv
// Forward model for the Gauss-Seidel solver: receives a 16-element x frame,
// computes b = A*x for the fixed banded matrix one row per cycle, then streams b out.
module gsim_rhs_gen (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_en,
  input  logic signed [31:0] x_in,
  output logic               busy,
  output logic               out_valid,
  output logic signed [37:0] b_out,
  output logic signed [15:0] b_sat
);

  typedef enum logic [1:0] {S_RECEIVE, S_CALC, S_SEND} state_t;

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic signed [31:0] x_buf   [16];
  logic signed [37:0] res_buf [16];

  logic [4:0]         nidx [7];
  logic signed [37:0] xn   [7];
  logic signed [37:0] s1, s2, s3, row_val;
  logic signed [21:0] r;

  // Window x_{cnt-3}..x_{cnt+3}; bit 4 of the 5-bit index flags an out-of-range neighbour.
  always_comb begin
    for (int k = 0; k < 7; k++) begin
      nidx[k] = {1'b0, cnt_q} + 5'(k) - 5'd3;
      xn[k]   = nidx[k][4] ? '0 : {{6{x_buf[nidx[k][3:0]][31]}}, x_buf[nidx[k][3:0]]};
    end
    s1      = xn[2] + xn[4];
    s2      = xn[1] + xn[5];
    s3      = xn[0] + xn[6];
    row_val = (xn[3] <<< 4) + (xn[3] <<< 2)
            - ((s1 <<< 3) + (s1 <<< 2) + s1)
            + (s2 <<< 2) + (s2 <<< 1)
            - s3;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_RECEIVE;
      cnt_q   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: the buffers carry no reset; every entry is rewritten before it is read.
  always_ff @(posedge clk) begin
    if (state_q == S_RECEIVE && in_en) x_buf[cnt_q] <= x_in;
    if (state_q == S_CALC)             res_buf[cnt_q] <= row_val;
  end

  // NOTE: every output of this block gets a default first, so no latch can be inferred.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    busy      = 1'b0;
    out_valid = 1'b0;
    b_out     = '0;
    case (state_q)
      S_RECEIVE: begin
        if (in_en) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd15) state_d = S_CALC;
        end
      end
      S_CALC: begin
        busy  = 1'b1;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) state_d = S_SEND;
      end
      S_SEND: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        b_out     = res_buf[cnt_q];
        cnt_d     = cnt_q + 4'd1;
        if (cnt_q == 4'd15) state_d = S_RECEIVE;
      end
      default: begin
        state_d = S_RECEIVE;
        cnt_d   = '0;
      end
    endcase
  end

  // Round half-up to integer, then clamp to the solver's 16-bit b_in range.
  always_comb begin
    r = 22'((b_out + 38'sh8000) >>> 16);
    if (r > 22'sd32767)       b_sat = 16'sh7FFF;
    else if (r < -22'sd32768) b_sat = 16'sh8000;
    else                      b_sat = r[15:0];
  end

endmodule

// File: tb/tb_gsim_rhs_gen.sv
// Self-checking bench for gsim_rhs_gen: directed and random frames against a
// coefficient-table model of b = A*x with half-up rounding and saturation.
module tb_gsim_rhs_gen;

  logic               clk = 1'b0;
  logic               reset;
  logic               in_en;
  logic signed [31:0] x_in;
  logic               busy;
  logic               out_valid;
  logic signed [37:0] b_out;
  logic signed [15:0] b_sat;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0]        xv [16];
  logic signed [63:0] got_b [16];
  logic signed [63:0] got_s [16];
  logic signed [63:0] prev_b [16];
  bit                 gap_mode  = 0;
  bit                 junk_mode = 0;

  gsim_rhs_gen dut (
    .clk       (clk),
    .reset     (reset),
    .in_en     (in_en),
    .x_in      (x_in),
    .busy      (busy),
    .out_valid (out_valid),
    .b_out     (b_out),
    .b_sat     (b_sat)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint model_b(input int i);
    int     coef [7] = '{-1, 6, -13, 20, -13, 6, -1};
    longint acc = 0;
    for (int d = -3; d <= 3; d++)
      if (i + d >= 0 && i + d < 16)
        acc += longint'(coef[d + 3]) * longint'($signed(xv[i + d]));
    return acc;
  endfunction

  function automatic longint model_sat(input longint b);
    longint q = (b + 64'sd32768) >>> 16;
    if (q > 32767)  return 32767;
    if (q < -32768) return -32768;
    return q;
  endfunction

  task automatic send_words(input int n);
    for (int i = 0; i < n; i++) begin
      if (gap_mode) begin
        int g = $urandom_range(0, 3);
        for (int k = 0; k < g; k++) begin
          in_en = 1'b0;
          x_in  = $urandom;
          @(posedge clk); #1;
        end
      end
      in_en = 1'b1;
      x_in  = xv[i];
      @(posedge clk); #1;
      in_en = 1'b0;
    end
  endtask

  task automatic drive_busy_input();
    in_en = junk_mode;
    x_in  = $urandom;
  endtask

  // Waits for out_valid and returns the number of cycles after the last accepted word.
  task automatic wait_output(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      drive_busy_input();
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_frame(input string tag);
    int lat;
    send_words(16);
    drive_busy_input();
    check({tag, " busy_after_last"}, busy, 1);
    wait_output(lat);
    check({tag, " latency"}, lat, 16);
    for (int i = 0; i < 16; i++) begin
      got_b[i] = b_out;
      got_s[i] = b_sat;
      check($sformatf("%s valid[%0d]", tag, i), out_valid, 1);
      check($sformatf("%s b_out[%0d]", tag, i), b_out, model_b(i));
      check($sformatf("%s b_sat[%0d]", tag, i), b_sat, model_sat(model_b(i)));
      in_en = junk_mode && (i < 15);
      x_in  = $urandom;
      @(posedge clk); #1;
    end
    in_en = 1'b0;
    check({tag, " valid_end"}, out_valid, 0);
    check({tag, " busy_end"}, busy, 0);
  endtask

  task automatic fill_const(input logic [31:0] v);
    for (int i = 0; i < 16; i++) xv[i] = v;
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 16; i++) xv[i] = $urandom;
  endtask

  initial begin
    int lat;
    reset = 1'b1;
    in_en = 1'b0;
    x_in  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", busy, 0);
    check("reset valid", out_valid, 0);
    check("reset b_out", b_out, 0);
    check("reset b_sat", b_sat, 0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;

    fill_const(32'h0001_0000);
    run_frame("ones");
    check("ones b_sat0", got_s[0], 12);
    check("ones b_sat1", got_s[1], -1);
    check("ones b_sat2", got_s[2], 5);
    check("ones b_sat7", got_s[7], 4);
    check("ones b_out0", got_b[0], 64'sh000C_0000);

    fill_const(32'h0);
    xv[7] = 32'h0001_0000;
    run_frame("impulse");
    check("impulse b_out7", got_b[7], 20 * 65536);
    check("impulse b_out4", got_b[4], -65536);
    check("impulse b_out3", got_b[3], 0);

    fill_const(32'h0);
    xv[3] = 32'h0000_8000;
    run_frame("half");
    check("half b_out2", got_b[2], -425984);
    check("half b_sat0", got_s[0], 0);
    check("half b_sat2", got_s[2], -6);
    check("half b_sat4", got_s[4], -6);

    fill_const(32'h7FFF_FFFF);
    run_frame("max");
    check("max b_out3", got_b[3], 64'sd4 * 64'sd2147483647);
    check("max b_sat9", got_s[9], 32767);

    fill_const(32'h8000_0000);
    run_frame("min");
    check("min b_out0", got_b[0], -64'sd12 * 64'sd2147483648);
    check("min b_sat15", got_s[15], -32768);

    fill_rand();
    run_frame("rand_nogap");
    for (int i = 0; i < 16; i++) prev_b[i] = got_b[i];
    gap_mode = 1;
    run_frame("rand_gap");
    gap_mode = 0;
    for (int i = 0; i < 16; i++) check($sformatf("gap_vs_nogap[%0d]", i), got_b[i], prev_b[i]);

    fill_rand();
    junk_mode = 1;
    run_frame("junk");
    junk_mode = 0;

    fill_rand();
    run_frame("b2b_a");
    fill_rand();
    run_frame("b2b_b");

    fill_rand();
    send_words(16);
    wait_output(lat);
    check("rst_send latency", lat, 16);
    repeat (5) begin @(posedge clk); #1; end
    check("rst_send pre_valid", out_valid, 1);
    reset = 1'b1;
    #1;
    check("rst_send valid", out_valid, 0);
    check("rst_send b_out", b_out, 0);
    check("rst_send b_sat", b_sat, 0);
    check("rst_send busy", busy, 0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    fill_rand();
    run_frame("after_rst_send");

    fill_rand();
    send_words(9);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    fill_rand();
    gap_mode = 1;
    run_frame("after_rst_recv");
    gap_mode = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/gsim_rhs_gen.md
# gsim_rhs_gen

Forward-model companion to the Gauss-Seidel solver: accepts a 16-element solution vector x and computes the right-hand side b = A·x for the solver's fixed 16×16 banded matrix. It is used to close the loop around the solver. Solver output x_out feeds this block, and this block's b produces a residual check or regenerates a solver input frame. It uses the same receive/compute/send frame protocol as the solver, with the data directions swapped.

## Interface
- No parameters. N = 16 and the coefficients are fixed.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  reset, asynchronous, active-high.
- in_en  in  1  x_in valid this cycle; honoured only in RECEIVE.
- x_in  in  32  signed Q16.16 element x_i, sent in index order 0..15.
- busy  out  1  high in CALC and SEND; in_en is ignored while high.
- out_valid  out  1  high for exactly 16 consecutive cycles per frame.
- b_out  out  38  signed Q22.16 exact row result b_i; index order 0..15.
- b_sat  out  16  signed integer: b_out rounded half-up and saturated; directly usable as a solver b_in.

## Operation
- Matrix row i: b_i = 20·x_i − 13·(x_{i−1}+x_{i+1}) + 6·(x_{i−2}+x_{i+2}) − (x_{i−3}+x_{i+3}).
  - Any x_j with j outside 0..15 is taken as 0.
- Storage:
  - x buffer: 16×32.
  - Result buffer: 16×38.
- Arithmetic:
  - Shift-add only; no multipliers.
  - ×20 = (x<<4)+(x<<2); ×13 = (x<<3)+(x<<2)+x; ×6 = (x<<2)+(x<<1).
  - All terms are sign-extended to 38 bits. Since Σ|coef| = 60, the result is exact and never overflows.
- b_sat derivation:
  - r = (b_out + 0x8000) >>> 16, arithmetic shift.
  - Clamp r to [−32768, 32767].
- State machine: counter cnt[3:0].
- RECEIVE:
  - Each cycle with in_en=1: x[cnt] ← x_in, cnt++.
  - Gaps with in_en=0 are allowed; cnt holds during a gap.
  - On the 16th accepted word (cnt=15): go to CALC, cnt ← 0.
- CALC:
  - One row per cycle: result[cnt] ← row(cnt), cnt++.
  - After cnt=15: go to SEND, cnt ← 0.
- SEND:
  - out_valid=1; b_out = result[cnt] and b_sat = sat(result[cnt]).
  - cnt++ each cycle. After cnt=15: go to RECEIVE, cnt ← 0.
  - There is no downstream stall; the sink must accept every word.
- Outputs outside SEND: b_out=0 and b_sat=0.
- Reset values:
  - State RECEIVE, cnt=0.
  - busy=0, out_valid=0, b_out=0, b_sat=0.
  - The x and result buffers need not be reset: every entry is rewritten before it is read.
- Reset mid-frame, in any state: the partial frame is discarded. After release, the next accepted word is x_0.
- in_en while busy=1: the data is dropped and no state changes; the word is not queued.

## Timing
- The 16th accepted x_in is sampled at edge E. From E: busy=1, CALC for 16 cycles.
- From edge E+16: out_valid=1 with index 0.
- Words: b_15 is presented in the cycle after edge E+31.
- At edge E+32: out_valid=0, busy=0, and RECEIVE resumes.
- Minimum frame period: 48 cycles (16 receive + 16 calc + 16 send).
- A new frame's in_en may be asserted in the first cycle with busy=0, which gives back-to-back frames.
- b_out and b_sat are functions of registered state only: stable for the whole cycle, with no combinational path from x_in or in_en.

## Test plan
- All x = 0x00010000 (1.0): b_sat sequence is 12, −1, 5, 4, …, 4 (indices 3..12), 5, −1, 12.
  - b_out equals each value × 2^16, e.g. 0x000C0000 for 12.
  - out_valid is high for exactly 16 cycles, starting 16 cycles after the last input edge.
- Impulse x_7 = 1.0, all others 0: b_4..b_10 = −1, 6, −13, 20, −13, 6, −1; all other b = 0, exact in b_out.
- Rounding with x_3 = 0x00008000 (0.5), others 0:
  - b_0..b_6 b_out = −0.5, 3, −6.5, 10, −6.5, 3, −0.5.
  - b_sat = 0, 3, −6, 10, −6, 3, 0 (half-up rounding).
- Saturation:
  - All x = 0x7FFFFFFF: b_sat = 32767 for every row, and b_out[3] = 4·(2^31−1).
  - All x = 0x80000000: b_sat = −32768 for every row, and b_out[0] = −12·2^31.
- Protocol:
  - Receive 16 words with random in_en gaps: the result must be identical to the gap-free case.
  - Assert in_en with junk data throughout CALC and SEND: no effect on the result.
  - Two back-to-back frames: both produce correct results.
- Reset:
  - Assert reset in the middle of SEND (index 5): out_valid, b_out and b_sat drop to 0 immediately.
  - After release, a full fresh frame produces the correct result.
  - Assert reset after 9 received words: the stale words are discarded.
